// File: rtl/tio_wb_cmd_master.sv
// rtl/tio_wb_cmd_master.sv - byte-stream command to single-cycle Wishbone initiator
// Parses WE/address/data command bytes, runs one Wishbone cycle, returns status (+ read data).
module tio_wb_cmd_master #(
  parameter int TIMEOUT      = 255,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [7:0]  cmd_tdata,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  output logic [7:0]  rsp_tdata,
  output logic        rsp_tvalid,
  input  logic        rsp_tready,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [11:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, WB, RSP} state_t;

  localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic                    we_q;
  logic [11:2]             adr_q;
  logic [31:0]             dat_q;
  logic [31:0]             rdat_q;
  logic [1:0]              status_q, status_d;
  logic [1:0]              dcnt_q;
  logic [2:0]              rcnt_q;
  logic [TIMEOUT_BITS-1:0] to_cnt_q;

  logic cmd_fire, rsp_fire, wb_done, rsp_last;

  assign cmd_fire = cmd_tvalid && cmd_tready;
  assign rsp_fire = rsp_tvalid && rsp_tready;
  assign wb_done  = wb_ack_i || wb_err_i || wb_rty_i || (to_cnt_q == TO_LAST);
  assign rsp_last = we_q ? (rcnt_q == 3'd0) : (rcnt_q == 3'd4);

  // Gating with reset keeps tready low while held in reset even though HDR0 accepts.
  assign cmd_tready = wb_rst_ni && (state_q == HDR0 || state_q == HDR1 || state_q == DATA);
  assign wb_cyc_o   = (state_q == WB);
  assign wb_stb_o   = wb_cyc_o;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = {adr_q, 2'b00};
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = 4'hF;
  assign rsp_tvalid = (state_q == RSP);
  assign busy_o     = (state_q != HDR0);

  always_comb begin
    status_d = 2'd3;
    if (wb_ack_i)      status_d = 2'd0;
    else if (wb_err_i) status_d = 2'd1;
    else if (wb_rty_i) status_d = 2'd2;
  end

  always_comb begin
    rsp_tdata = 8'h00;
    if (rsp_tvalid) begin
      case (rcnt_q)
        3'd0:    rsp_tdata = {6'b0, status_q};
        3'd1:    rsp_tdata = rdat_q[31:24];
        3'd2:    rsp_tdata = rdat_q[23:16];
        3'd3:    rsp_tdata = rdat_q[15:8];
        3'd4:    rsp_tdata = rdat_q[7:0];
        default: rsp_tdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= HDR0;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR0: if (cmd_fire) state_d = HDR1;
      HDR1: if (cmd_fire) state_d = we_q ? DATA : WB;
      DATA: if (cmd_fire && dcnt_q == 2'd3) state_d = WB;
      WB:   if (wb_done) state_d = RSP;
      RSP:  if (rsp_fire && rsp_last) state_d = HDR0;
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      rdat_q   <= '0;
      status_q <= '0;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      to_cnt_q <= '0;
    end else begin
      case (state_q)
        HDR0: begin
          dcnt_q   <= '0;
          rcnt_q   <= '0;
          to_cnt_q <= '0;
          if (cmd_fire) begin
            we_q  <= cmd_tdata[7];
            adr_q <= {cmd_tdata[3:0], 6'b0};
          end
        end
        HDR1: if (cmd_fire) adr_q[7:2] <= cmd_tdata[7:2];
        DATA: if (cmd_fire) begin
          dat_q  <= {dat_q[23:0], cmd_tdata};
          dcnt_q <= dcnt_q + 2'd1;
        end
        WB: begin
          if (!wb_done) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end else begin
            status_q <= status_d;
            // Read data only survives an ack; every other ending reports zeros.
            rdat_q   <= (wb_ack_i && !we_q) ? wb_dat_i : 32'h0;
          end
        end
        RSP: if (rsp_fire) rcnt_q <= rcnt_q + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tio_wb_cmd_master.sv
// tb/tb_tio_wb_cmd_master.sv - directed self-checking bench for tio_wb_cmd_master
// Small Wishbone target model answers each cycle per the mode/delay set by each step.
module tb_tio_wb_cmd_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic [7:0]  cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  rsp_tdata;
  logic        rsp_tvalid;
  logic        rsp_tready;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [11:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  // target model controls: 0 none, 1 ack, 2 err, 3 rty, 4 ack+err
  int          mode    = 0;
  int          resp_at = 0;
  logic [31:0] rdata   = 32'h0;

  int          cyc_cnt  = 0;
  int          last_len = 0;
  logic [11:0] cap_adr  = '0;
  logic        cap_we   = 1'b0;
  logic [31:0] cap_dat  = '0;
  logic [3:0]  cap_sel  = '0;
  logic        unstable = 1'b0;
  logic        stb_bad  = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  tio_wb_cmd_master #(.TIMEOUT(8), .TIMEOUT_BITS(16)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .cmd_tdata  (cmd_tdata),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .rsp_tdata  (rsp_tdata),
    .rsp_tvalid (rsp_tvalid),
    .rsp_tready (rsp_tready),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_rty_i   (wb_rty_i),
    .busy_o     (busy_o)
  );

  always_comb begin
    logic hit;
    hit      = wb_cyc_o && (cyc_cnt == resp_at);
    wb_ack_i = hit && (mode == 1 || mode == 4);
    wb_err_i = hit && (mode == 2 || mode == 4);
    wb_rty_i = hit && (mode == 3);
    wb_dat_i = hit ? rdata : 32'hFFFF_FFFF;
  end

  always @(posedge wb_clk_i) begin
    if (wb_cyc_o) begin
      cyc_cnt <= cyc_cnt + 1;
      if (cyc_cnt != 0 && (wb_adr_o !== cap_adr || wb_we_o !== cap_we || wb_dat_o !== cap_dat))
        unstable <= 1'b1;
      cap_adr <= wb_adr_o;
      cap_we  <= wb_we_o;
      cap_dat <= wb_dat_o;
      cap_sel <= wb_sel_o;
    end else begin
      if (cyc_cnt != 0) last_len <= cyc_cnt;
      cyc_cnt <= 0;
    end
    if (wb_stb_o !== wb_cyc_o) stb_bad <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_tdata  = b;
    cmd_tvalid = 1'b1;
    while (!cmd_tready && n < 300) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    if (!cmd_tready) chk("cmd_accept_timeout", {31'b0, cmd_tready}, 32'h1);
    else begin
      @(posedge wb_clk_i); #1;
    end
    cmd_tvalid = 1'b0;
  endtask

  task automatic send_rd(input logic [7:0] b0, input logic [7:0] b1);
    send_byte(b0);
    send_byte(b1);
  endtask

  task automatic send_wr(input logic [7:0] b0, input logic [7:0] b1, input logic [31:0] d);
    send_byte(b0);
    send_byte(b1);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic recv_exp(input string tag, input logic [7:0] exp);
    int n = 0;
    rsp_tready = 1'b1;
    while (!rsp_tvalid && n < 300) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    if (!rsp_tvalid) chk({tag, "_timeout"}, {31'b0, rsp_tvalid}, 32'h1);
    else begin
      chk(tag, rsp_tdata, exp);
      @(posedge wb_clk_i); #1;
    end
    rsp_tready = 1'b0;
  endtask

  task automatic recv5(input string tag, input logic [7:0] st, input logic [31:0] d);
    recv_exp({tag, "_st"}, st);
    recv_exp({tag, "_b3"}, d[31:24]);
    recv_exp({tag, "_b2"}, d[23:16]);
    recv_exp({tag, "_b1"}, d[15:8]);
    recv_exp({tag, "_b0"}, d[7:0]);
  endtask

  initial begin
    logic [7:0] got_bytes [5];
    logic [7:0] bp_exp [5];
    int         got;
    int         n;
    logic       stable;
    logic       ready_leak;

    wb_rst_ni  = 1'b0;
    cmd_tdata  = 8'h00;
    cmd_tvalid = 1'b0;
    rsp_tready = 1'b0;

    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'b0, wb_stb_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_rsp_tvalid", {31'b0, rsp_tvalid}, 32'h0);
    chk("rst_cmd_tready", {31'b0, cmd_tready}, 32'h0);
    chk("rst_adr", {20'b0, wb_adr_o}, 32'h0);
    chk("rst_sel", {28'b0, wb_sel_o}, 32'hF);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    #1;
    chk("post_rst_cmd_tready", {31'b0, cmd_tready}, 32'h1);

    // read, ack on second cyc cycle
    mode = 1; resp_at = 1; rdata = 32'h1234_5678;
    send_rd(8'h00, 8'h04);
    recv5("rd", 8'h00, 32'h1234_5678);
    chk("rd_adr", {20'b0, cap_adr}, 32'h004);
    chk("rd_we", {31'b0, cap_we}, 32'h0);
    chk("rd_len", last_len, 32'd2);
    chk("rd_sel", {28'b0, cap_sel}, 32'hF);

    // write, immediate ack, minimum latency
    mode = 1; resp_at = 0;
    send_byte(8'h80); send_byte(8'h0C);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("wr_cyc_rise", {31'b0, wb_cyc_o}, 32'h1);
    @(posedge wb_clk_i); #1;
    chk("wr_rsp_latency", {31'b0, rsp_tvalid}, 32'h1);
    chk("wr_cyc_fall", {31'b0, wb_cyc_o}, 32'h0);
    recv_exp("wr_st", 8'h00);
    chk("wr_adr", {20'b0, cap_adr}, 32'h00C);
    chk("wr_dat", cap_dat, 32'hDEAD_BEEF);
    chk("wr_we", {31'b0, cap_we}, 32'h1);
    chk("wr_len", last_len, 32'd1);
    chk("wr_busy_after", {31'b0, busy_o}, 32'h0);
    chk("wr_single_byte", {31'b0, rsp_tvalid}, 32'h0);

    // timeout at TIMEOUT=8
    mode = 0;
    send_rd(8'h0F, 8'hFF);
    recv5("to", 8'h03, 32'h0);
    chk("to_adr", {20'b0, cap_adr}, 32'hFFC);
    chk("to_len", last_len, 32'd8);

    // err on read: data forced to zero
    mode = 2; resp_at = 2; rdata = 32'hCAFE_F00D;
    send_rd(8'h01, 8'h20);
    recv5("err", 8'h01, 32'h0);
    chk("err_adr", {20'b0, cap_adr}, 32'h120);
    chk("err_len", last_len, 32'd3);

    // rty on write
    mode = 3; resp_at = 0;
    send_wr(8'h80, 8'h10, 32'h1122_3344);
    recv_exp("rty_st", 8'h02);
    chk("rty_single_byte", {31'b0, rsp_tvalid}, 32'h0);
    chk("rty_adr", {20'b0, cap_adr}, 32'h010);
    chk("rty_dat", cap_dat, 32'h1122_3344);

    // ack and err together: ack wins, data captured
    mode = 4; resp_at = 0; rdata = 32'h0BAD_BEEF;
    send_rd(8'h02, 8'h30);
    recv5("ackerr", 8'h00, 32'h0BAD_BEEF);
    chk("ackerr_adr", {20'b0, cap_adr}, 32'h230);

    // rty on the timeout threshold cycle counts as rty
    mode = 3; resp_at = 7;
    send_rd(8'h00, 8'h40);
    recv5("thr", 8'h02, 32'h0);
    chk("thr_len", last_len, 32'd8);

    // backpressure: hold tready low 10 cycles then toggle
    mode = 1; resp_at = 0; rdata = 32'hA1B2_C3D4;
    send_rd(8'h00, 8'h08);
    n = 0;
    while (!rsp_tvalid && n < 100) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    chk("bp_valid", {31'b0, rsp_tvalid}, 32'h1);
    cmd_tdata = 8'h80; cmd_tvalid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      if (rsp_tdata !== 8'h00 || !rsp_tvalid || cmd_tready) stable = 1'b0;
      @(posedge wb_clk_i); #1;
    end
    chk("bp_hold_stable", {31'b0, stable}, 32'h1);
    got = 0;
    ready_leak = 1'b0;
    for (int i = 0; i < 40 && got < 5; i++) begin
      rsp_tready = i[0];
      if (cmd_tready) ready_leak = 1'b1;
      if (rsp_tready && rsp_tvalid) begin
        got_bytes[got] = rsp_tdata;
        got++;
      end
      @(posedge wb_clk_i); #1;
    end
    rsp_tready = 1'b0;
    cmd_tvalid = 1'b0;
    chk("bp_count", got, 32'd5);
    chk("bp_cmd_tready_low", {31'b0, ready_leak}, 32'h0);
    bp_exp[0] = 8'h00; bp_exp[1] = 8'hA1; bp_exp[2] = 8'hB2; bp_exp[3] = 8'hC3; bp_exp[4] = 8'hD4;
    for (int i = 0; i < 5; i++) chk($sformatf("bp_b%0d", i), got_bytes[i], bp_exp[i]);
    chk("bp_idle", {31'b0, busy_o}, 32'h0);

    // reset in the middle of a cycle
    mode = 0;
    send_rd(8'h01, 8'h00);
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("mid_cyc_high", {31'b0, wb_cyc_o}, 32'h1);
    #2;
    wb_rst_ni = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("mid_rst_stb", {31'b0, wb_stb_o}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
    chk("mid_rst_rsp_tvalid", {31'b0, rsp_tvalid}, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    #1;
    mode = 1; resp_at = 0; rdata = 32'h55AA_33CC;
    send_rd(8'h00, 8'h44);
    recv5("post", 8'h00, 32'h55AA_33CC);
    chk("post_adr", {20'b0, cap_adr}, 32'h044);
    chk("post_len", last_len, 32'd1);

    chk("stb_eq_cyc", {31'b0, stb_bad}, 32'h0);
    chk("bus_stable", {31'b0, unstable}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
